// File: rtl/descramble_pkg.sv
// descramble_pkg: scrambler constants, FSM states and key tap shared by the 100BASE-TX receive descrambler
package descramble_pkg;
    localparam int SCR_LEN = 11;
    localparam int TAP_A = 10;
    localparam int TAP_B = 8;
    localparam int LOCK_BITS_DEF = 29;
    localparam int UNLOCK_CYCLES_DEF = 90250;

    typedef enum logic {UNLOCKED, LOCKED} state_t;

    function automatic logic scr_key(input logic [SCR_LEN-1:0] lfsr);
        return lfsr[TAP_A] ^ lfsr[TAP_B];
    endfunction
endpackage

// File: rtl/descramble.sv
// descramble: X^11+X^9+1 descrambler that self-synchronises on idle and tracks lock with a hold timer
module descramble
    import descramble_pkg::*;
#(
    parameter int LOCK_BITS = LOCK_BITS_DEF,
    parameter int UNLOCK_CYCLES = UNLOCK_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] nrz,
    input  logic [1:0] nrz_valid,
    output logic [1:0] data,
    output logic [1:0] data_valid,
    output logic       locked
);
    localparam int CW = $clog2(LOCK_BITS + 2);
    localparam int TW = $clog2(UNLOCK_CYCLES + 1);
    localparam int FW = $clog2(SCR_LEN + 1);

    typedef struct packed {
        logic [SCR_LEN-1:0] lfsr;
        logic [FW-1:0]      fill;
        logic [CW-1:0]      match;
        logic [CW-1:0]      run;
    } bit_st_t;

    state_t        state, state_nx;
    bit_st_t       st, st_a, st_b, st_nx;
    logic [TW-1:0] timer, timer_nx;
    logic [1:0]    data_nx, data_valid_nx;
    logic          lk;

    // While unlocked the line is assumed idle, so the inverted bit is the key stream
    function automatic bit_st_t step(input bit_st_t s, input logic l, input logic b);
        bit_st_t r;
        logic    o;
        r = s;
        o = b ^ scr_key(s.lfsr);
        r.lfsr = {s.lfsr[SCR_LEN-2:0], l ? b : ~b};
        if (l) begin
            r.run = o ? ((s.run == CW'(LOCK_BITS)) ? s.run : s.run + 1'b1) : '0;
        end else begin
            r.fill = (s.fill == FW'(SCR_LEN)) ? s.fill : s.fill + 1'b1;
            if (s.fill == FW'(SCR_LEN))
                r.match = o ? ((s.match == CW'(LOCK_BITS + 1)) ? s.match : s.match + 1'b1) : '0;
        end
        return r;
    endfunction

    assign lk = (state == LOCKED);

    always_comb begin
        st_a = (|nrz_valid) ? step(st, lk, nrz[1]) : st;
        st_b = nrz_valid[1] ? step(st_a, lk, nrz[0]) : st_a;
        data_nx = {nrz[1] ^ scr_key(st.lfsr), nrz[0] ^ scr_key(st_a.lfsr)};
        st_nx = st_b;
        timer_nx = timer;
        state_nx = state;
        data_valid_nx = 2'b00;
        if (!lk) begin
            if (st_b.match >= CW'(LOCK_BITS)) begin
                state_nx = LOCKED;
                timer_nx = TW'(UNLOCK_CYCLES);
                st_nx.run = '0;
            end
        end else if (st_b.run >= CW'(LOCK_BITS)) begin
            timer_nx = TW'(UNLOCK_CYCLES);
            st_nx.run = '0;
            data_valid_nx = nrz_valid;
        end else begin
            timer_nx = (timer == '0) ? timer : timer - 1'b1;
            if (timer_nx == '0) begin
                state_nx = UNLOCKED;
                st_nx.fill = '0;
                st_nx.match = '0;
            end else begin
                data_valid_nx = nrz_valid;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= UNLOCKED;
            st <= '0;
            timer <= '0;
            data <= '0;
            data_valid <= '0;
            locked <= 1'b0;
        end else begin
            state <= state_nx;
            st <= st_nx;
            timer <= timer_nx;
            data <= data_nx;
            data_valid <= data_valid_nx;
            locked <= (state_nx == LOCKED);
        end
    end
endmodule

// File: tb/tb_descramble.sv
// tb_descramble: random-stimulus bench with a bit-history reference model of the descrambler
module tb_descramble;
    localparam int LB = 29;
    localparam int U = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] nrz = '0;
    logic [1:0] nrz_valid = '0;
    logic [1:0] data, data_valid;
    logic       locked;

    int checks = 0;
    int errors = 0;

    descramble #(.LOCK_BITS(LB), .UNLOCK_CYCLES(U)) dut (
        .clk(clk), .rst_n(rst_n), .nrz(nrz), .nrz_valid(nrz_valid),
        .data(data), .data_valid(data_valid), .locked(locked)
    );

    always #5 clk = ~clk;

    // Reference: dq = every bit ever loaded into the descrambler, sq = transmitted scrambler history
    logic dq[$];
    logic sq[$];
    logic oq[$];
    logic pt[$];
    int   m_fill, m_match, m_run, m_timer, e_dv, cyc, last_refresh;
    logic m_locked;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int nb(input logic [1:0] v);
        return v[1] ? 2 : int'(v[0]);
    endfunction

    task automatic model_reset();
        dq = {};
        repeat (11) dq.push_back(1'b0);
        m_fill = 0; m_match = 0; m_run = 0; m_timer = 0; m_locked = 1'b0; e_dv = 0;
    endtask

    task automatic scr_reset();
        sq = {};
        repeat (11) sq.push_back(1'b1);
    endtask

    task automatic mbit(input logic b, output logic o);
        o = b ^ dq[dq.size()-11] ^ dq[dq.size()-9];
        if (!m_locked) begin
            if (m_fill == 11) m_match = o ? ((m_match < LB + 1) ? m_match + 1 : m_match) : 0;
            m_fill = (m_fill < 11) ? m_fill + 1 : 11;
            dq.push_back(!b);
        end else begin
            m_run = o ? ((m_run < LB) ? m_run + 1 : LB) : 0;
            dq.push_back(b);
        end
    endtask

    task automatic send(input logic [1:0] v, input logic [1:0] p, input logic [1:0] flip);
        logic [1:0] line, eo;
        logic s, o;
        int n;
        n = nb(v);
        line = 2'($urandom);
        eo = '0;
        cyc++;
        for (int i = 0; i < n; i++) begin
            s = p[1-i] ^ sq[sq.size()-11] ^ sq[sq.size()-9];
            sq.push_back(s);
            line[1-i] = s ^ flip[1-i];
            mbit(line[1-i], o);
            eo[1-i] = o;
        end
        if (!m_locked) begin
            e_dv = 0;
            if (m_match >= LB) begin m_locked = 1'b1; m_timer = U; m_run = 0; last_refresh = cyc; end
        end else if (m_run >= LB) begin
            m_timer = U; m_run = 0; e_dv = int'(v); last_refresh = cyc;
        end else begin
            m_timer--;
            if (m_timer == 0) begin m_locked = 1'b0; m_fill = 0; m_match = 0; e_dv = 0; end
            else e_dv = int'(v);
        end
        nrz = line;
        nrz_valid = v;
        @(posedge clk);
        #1;
        check("locked", locked, m_locked);
        check("data_valid", data_valid, e_dv);
        if (e_dv != 0)
            for (int i = 0; i < n; i++) begin
                check("data", data[1-i], eo[1-i]);
                oq.push_back(data[1-i]);
            end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        nrz_valid = '0;
        @(posedge clk);
        #1;
        model_reset();
        scr_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int lock_at, cum, exp_lb, dut_lb, n, fall, lk, idx;
        logic [1:0] v, p, f;
        logic flipped;
        logic [9:0] jk;
        cyc = 0;
        last_refresh = 0;
        model_reset();
        scr_reset();
        repeat (4) begin
            nrz = 2'($urandom);
            nrz_valid = 2'd2;
            @(posedge clk);
            #1;
            check("rst_locked", locked, 0);
            check("rst_dv", data_valid, 0);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("rel_locked", locked, 0);
        check("rel_dv", data_valid, 0);

        lock_at = 0;
        for (int c = 1; c <= 30; c++) begin
            send(2'd2, 2'b11, 2'b00);
            if (locked && lock_at == 0) lock_at = c;
        end
        check("acq_pairs", lock_at, 20);

        do_reset();
        cum = 0; exp_lb = 0; dut_lb = 0;
        for (int c = 0; c < 200 && dut_lb == 0; c++) begin
            v = 2'($urandom_range(0, 3));
            n = nb(v);
            send(v, 2'b11, 2'b00);
            cum += n;
            if (exp_lb == 0 && cum >= 40) exp_lb = cum;
            if (locked) dut_lb = cum;
        end
        check("mix_lock_bits", dut_lb, exp_lb);

        repeat (10) send(2'd2, 2'b11, 2'b00);
        jk = 10'b11000_10001;
        pt = {};
        for (int i = 9; i >= 0; i--) pt.push_back(jk[i]);
        repeat (100) pt.push_back(1'($urandom));
        oq = {};
        idx = 0;
        while (idx < pt.size()) begin
            v = (idx == pt.size() - 1) ? 2'd1 : 2'($urandom_range(1, 2));
            p = {pt[idx], (v == 2'd2) ? pt[idx+1] : 1'b0};
            send(v, p, 2'b00);
            idx += nb(v);
        end
        check("frame_len", oq.size(), pt.size());
        for (int i = 0; i < pt.size() && i < oq.size(); i++) check("frame_bit", oq[i], pt[i]);
        check("frame_locked", locked, 1);

        repeat (15) send(2'd2, 2'b11, 2'b00);
        fall = 0;
        for (int c = 0; c < U + 50 && fall == 0; c++) begin
            send(2'd2, 2'b10, 2'b00);
            if (!locked) fall = cyc;
        end
        check("timeout_len", fall - last_refresh, U);

        lk = 0;
        for (int c = 0; c < 100 && lk == 0; c++) begin
            send(2'd2, 2'b11, 2'b00);
            if (locked) lk = cyc;
        end
        check("relock", locked, 1);
        repeat (U - 16) send(2'd2, 2'b10, 2'b00);
        repeat (15) send(2'd2, 2'b11, 2'b00);
        send(2'd2, 2'b10, 2'b00);
        check("refresh_keep", locked, 1);

        do_reset();
        flipped = 1'b0;
        lk = 0;
        for (int c = 1; c <= 120 && lk == 0; c++) begin
            f = (!flipped && m_fill == 11 && m_match == 27) ? 2'b01 : 2'b00;
            if (f != 2'b00) flipped = 1'b1;
            send(2'd2, 2'b11, f);
            if (c == 20) check("err_no_lock20", locked, 0);
            if (locked) lk = c;
        end
        check("err_relock", locked, 1);

        #2 rst_n = 1'b0;
        #1;
        check("midrst_locked", locked, 0);
        check("midrst_dv", data_valid, 0);
        model_reset();
        scr_reset();
        @(negedge clk);
        rst_n = 1'b1;
        lock_at = 0;
        for (int c = 1; c <= 30; c++) begin
            send(2'd2, 2'b11, 2'b00);
            if (locked && lock_at == 0) lock_at = c;
        end
        check("reacq_pairs", lock_at, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
